quad_decoder: RTL and testbench

Quadrature (A/B) decoder that turns two-phase incremental-encoder signals into direction, step pulses and a modulo-N position count. It is the input-side counterpart of the team's up/down mod-N counter. The same {direction, step, wrap-around} semantics are derived here from an external Gray-coded phase pair rather than from a supplied `up_down` level. Inputs are asynchronous to `clk`; the block synchronizes and filters them before decoding.

---
 rtl/quad_decoder.sv | 97 +++++++++
 tb/tb_quad_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizes and filters two encoder phases, then emits
// direction, one-cycle step/wrap pulses, a modulo-N position and a sticky illegal-move flag.
module quad_decoder #(
  parameter int unsigned N    = 16,
  parameter int unsigned W    = 4,
  parameter int unsigned FILT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_in,
  input  logic         b_in,
  output logic [W-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         wrap,
  output logic         err
);

  localparam int unsigned FcW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [W-1:0] CntMax = W'(N - 1);
  localparam logic [FcW-1:0] FcMax = FcW'(FILT - 1);

  logic [1:0]     s1_q, s2_q, ph_q, vld_q;
  logic [FcW-1:0] fc_q;
  logic           armed_q;
  logic [1:0]     delta;

  // Map {A,B} onto a 2-bit ring position so a legal move is +1 or -1 mod 4.
  function automatic logic [1:0] ring_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    delta = ring_pos(s2_q) - ring_pos(ph_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 2'b00;
      s2_q    <= 2'b00;
      vld_q   <= 2'b00;
      ph_q    <= 2'b00;
      fc_q    <= '0;
      armed_q <= 1'b0;
      count   <= '0;
      dir     <= 1'b1;
      step    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      s1_q  <= {a_in, b_in};
      s2_q  <= s1_q;
      vld_q <= {vld_q[0], 1'b1};
      step  <= 1'b0;
      wrap  <= 1'b0;
      if (!armed_q) begin
        // Arm only once s2 holds a post-reset input sample, not the cleared sync value.
        fc_q <= '0;
        if (vld_q[1]) begin
          ph_q    <= s2_q;
          armed_q <= 1'b1;
        end
      end else if (s2_q == ph_q) begin
        fc_q <= '0;
      end else if (fc_q == FcMax) begin
        fc_q <= '0;
        ph_q <= s2_q;
        case (delta)
          2'd1: begin
            step <= 1'b1;
            dir  <= 1'b1;
            if (count == CntMax) begin
              count <= '0;
              wrap  <= 1'b1;
            end else begin
              count <= count + W'(1);
            end
          end
          2'd3: begin
            step <= 1'b1;
            dir  <= 1'b0;
            if (count == '0) begin
              count <= CntMax;
              wrap  <= 1'b1;
            end else begin
              count <= count - W'(1);
            end
          end
          default: err <= 1'b1;
        endcase
      end else begin
        fc_q <= fc_q + FcW'(1);
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (N=16, W=4, FILT=2) using immediate assertions.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in, b_in;
  logic [3:0] count;
  logic       dir, step, wrap, err;

  int n_checks = 0;
  int n_fails  = 0;
  int step_cnt = 0;
  int wrap_cnt = 0;
  int p;
  int base_steps, base_wraps;
  logic [1:0] seq [4];

  quad_decoder #(.N(16), .W(4), .FILT(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_in (a_in),
    .b_in (b_in),
    .count(count),
    .dir  (dir),
    .step (step),
    .wrap (wrap),
    .err  (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) step_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_phase(input int idx);
    {a_in, b_in} = seq[idx & 3];
  endtask

  // One legal phase move (d = +1 up, -1 down), then settle for 6 cycles.
  task automatic move(input int d);
    p = (p + d) & 3;
    set_phase(p);
    cyc(6);
  endtask

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

    // Reset and arm with A/B = 11
    rst = 1'b0; a_in = 1'b1; b_in = 1'b1; p = 2;
    cyc(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dir",   32'(dir),   32'd1);
    check("rst_step",  32'(step),  32'd0);
    check("rst_wrap",  32'(wrap),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    rst = 1'b1;
    base_steps = step_cnt;
    cyc(8);
    check("arm_nostep", 32'(step_cnt - base_steps), 32'd0);
    check("arm_count",  32'(count), 32'd0);
    check("arm_err",    32'(err),   32'd0);

    // 17 forward moves: 0..15, wrap to 0, then 1
    base_steps = step_cnt; base_wraps = wrap_cnt;
    for (int i = 0; i < 17; i++) begin
      move(1);
      check("up_count", 32'(count), 32'((i + 1) % 16));
      check("up_wraps", 32'(wrap_cnt - base_wraps), (i >= 15) ? 32'd1 : 32'd0);
    end
    check("up_steps", 32'(step_cnt - base_steps), 32'd17);
    check("up_dir",   32'(dir), 32'd1);

    // Down from zero: 1 -> 0, then 0 -> 15 with wrap, then 15 -> 14
    move(-1);
    check("dn_zero", 32'(count), 32'd0);
    p = (p - 1) & 3;
    set_phase(p);
    cyc(4);
    check("dn_wrap_step",  32'(step),  32'd1);
    check("dn_wrap_pulse", 32'(wrap),  32'd1);
    check("dn_wrap_count", 32'(count), 32'd15);
    check("dn_wrap_dir",   32'(dir),   32'd0);
    cyc(1);
    check("dn_wrap_end",   32'(wrap),  32'd0);
    check("dn_step_end",   32'(step),  32'd0);
    cyc(1);
    base_wraps = wrap_cnt;
    move(-1);
    check("dn_count14", 32'(count), 32'd14);
    check("dn_nowrap",  32'(wrap_cnt - base_wraps), 32'd0);

    // Glitch of one cycle is rejected
    base_steps = step_cnt;
    set_phase(p + 1);
    cyc(1);
    set_phase(p);
    cyc(6);
    check("glitch_steps", 32'(step_cnt - base_steps), 32'd0);
    check("glitch_count", 32'(count), 32'd14);

    // Held change steps at the third edge after the input settles
    p = (p + 1) & 3;
    set_phase(p);
    cyc(3);
    check("held_early", 32'(step), 32'd0);
    cyc(1);
    check("held_step",  32'(step),  32'd1);
    check("held_count", 32'(count), 32'd15);
    cyc(2);
    check("held_one", 32'(step_cnt - base_steps), 32'd1);

    // Illegal 00 -> 11
    move(-1);
    check("pre_ill_phase", 32'(p), 32'd0);
    check("pre_ill_count", 32'(count), 32'd14);
    base_steps = step_cnt;
    p = 2;
    set_phase(p);
    cyc(6);
    check("ill_err",   32'(err),   32'd1);
    check("ill_count", 32'(count), 32'd14);
    check("ill_dir",   32'(dir),   32'd0);
    check("ill_step",  32'(step_cnt - base_steps), 32'd0);
    move(1);
    check("post_ill_count", 32'(count), 32'd15);
    check("post_ill_dir",   32'(dir),   32'd1);
    move(1);
    check("post_ill_wrap", 32'(count), 32'd0);
    check("err_sticky",    32'(err),   32'd1);

    // Reset mid-run at count 9 with a pending filter run
    for (int i = 0; i < 9; i++) move(1);
    check("mid_count9", 32'(count), 32'd9);
    p = (p + 1) & 3;
    set_phase(p);
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_step",  32'(step),  32'd0);
    check("mid_rst_err",   32'(err),   32'd0);
    check("mid_rst_dir",   32'(dir),   32'd1);
    rst = 1'b1;
    base_steps = step_cnt;
    cyc(8);
    check("mid_no_count", 32'(count), 32'd0);
    check("mid_no_step",  32'(step_cnt - base_steps), 32'd0);
    move(1);
    check("mid_rearm_up", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
